// File: rtl/wb_port_arbiter_pkg.sv
// ============================================================================
//  Module      : wb_port_arbiter_pkg
//  Description : Writeback mux select codes and core writeback source encoding,
//                shared by the port arbiter and the control unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_port_arbiter_pkg;

    localparam logic [3:0] WB_SEL_ALU  = 4'b0000;
    localparam logic [3:0] WB_SEL_LOAD = 4'b0100;
    localparam logic [3:0] WB_SEL_LINK = 4'b0101;
    localparam logic [3:0] WB_SEL_LUI  = 4'b0010;
    localparam logic [3:0] WB_SEL_MD   = 4'b1000;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_LOAD = 2'd1,
        SRC_LINK = 2'd2,
        SRC_LUI  = 2'd3
    } core_src_e;

    function automatic logic [3:0] wb_sel_code(input logic [1:0] src);
        case (core_src_e'(src))
            SRC_LOAD: wb_sel_code = WB_SEL_LOAD;
            SRC_LINK: wb_sel_code = WB_SEL_LINK;
            SRC_LUI:  wb_sel_code = WB_SEL_LUI;
            default:  wb_sel_code = WB_SEL_ALU;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_pend_fifo.sv
// ============================================================================
//  Module      : wb_pend_fifo
//  Description : 2-entry {addr,data} FIFO holding mul/div results; both entries
//                are exposed so the arbiter can hazard-check all of them.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_pend_fifo #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [4:0]    push_addr_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [1:0]    count_o,
    output logic [4:0]    head_addr_o,
    output logic [DW-1:0] head_data_o,
    output logic          ent0_valid_o,
    output logic [4:0]    ent0_addr_o,
    output logic          ent1_valid_o,
    output logic [4:0]    ent1_addr_o
);

    logic [4:0]    addr_q [2];
    logic [DW-1:0] data_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic [1:0]    count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                addr_q[wr_ptr_q] <= push_addr_i;
                data_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_addr_o  = addr_q[rd_ptr_q];
    assign head_data_o  = data_q[rd_ptr_q];
    // With one entry only the slot under the read pointer holds live data.
    assign ent0_valid_o = (count_q == 2'd2) || ((count_q == 2'd1) && !rd_ptr_q);
    assign ent1_valid_o = (count_q == 2'd2) || ((count_q == 2'd1) &&  rd_ptr_q);
    assign ent0_addr_o  = addr_q[0];
    assign ent1_addr_o  = addr_q[1];

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
//  Module      : wb_port_arbiter
//  Description : Owns the register-file write port; arbitrates core writeback
//                against buffered mul/div results and drives the wb mux select.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int bit_size   = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_wr_req,
    input  logic [1:0]          core_src,
    input  logic [4:0]          core_wr_addr,
    input  logic [4:0]          rs_addr,
    input  logic [4:0]          rt_addr,
    input  logic                md_valid,
    output logic                md_ready,
    input  logic [4:0]          md_addr,
    input  logic [bit_size-1:0] md_data,
    output logic [3:0]          wb_sel,
    output logic                wb_en,
    output logic [4:0]          wb_addr,
    output logic [bit_size-1:0] wb_md_data,
    output logic                core_stall
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [1:0]          w_count;
    logic [4:0]          w_head_addr;
    logic [bit_size-1:0] w_head_data;
    logic                w_ent_valid [2];
    logic [4:0]          w_ent_addr  [2];
    logic                w_push;
    logic                w_pop;
    logic                w_core_grant;
    logic                w_hazard;
    logic                w_starve;
    logic                w_pending;
    logic [SW-1:0]       starve_cnt_q;
    logic [SW-1:0]       starve_cnt_d;

    wb_pend_fifo #(
        .DW (bit_size)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (w_push),
        .push_addr_i  (md_addr),
        .push_data_i  (md_data),
        .pop_i        (w_pop),
        .count_o      (w_count),
        .head_addr_o  (w_head_addr),
        .head_data_o  (w_head_data),
        .ent0_valid_o (w_ent_valid[0]),
        .ent0_addr_o  (w_ent_addr[0]),
        .ent1_valid_o (w_ent_valid[1]),
        .ent1_addr_o  (w_ent_addr[1])
    );

    assign w_pending = (w_count != 2'd0);
    assign md_ready  = (w_count != 2'd2);
    assign w_push    = md_valid && md_ready;

    // Entries targeting $0 never conflict: the write is discarded anyway.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (w_ent_valid[i] && (w_ent_addr[i] != 5'd0)) begin
                if ((w_ent_addr[i] == rs_addr) || (w_ent_addr[i] == rt_addr)) begin
                    w_hazard = 1'b1;
                end
                if (core_wr_req && (w_ent_addr[i] == core_wr_addr)) begin
                    w_hazard = 1'b1;
                end
            end
        end
    end

    assign w_starve     = (starve_cnt_q == SW'(STARVE_MAX));
    assign core_stall   = w_hazard || w_starve;
    assign w_core_grant = core_wr_req && !core_stall;
    assign w_pop        = !w_core_grant && w_pending;

    always_comb begin
        wb_sel  = WB_SEL_ALU;
        wb_addr = 5'd0;
        if (w_core_grant) begin
            wb_sel  = wb_sel_code(core_src);
            wb_addr = core_wr_addr;
        end else if (w_pending) begin
            wb_sel  = WB_SEL_MD;
            wb_addr = w_head_addr;
        end
    end

    assign wb_en      = (w_core_grant || w_pop) && (wb_addr != 5'd0);
    assign wb_md_data = w_pending ? w_head_data : '0;

    // Saturating at the limit keeps core_stall asserted until the head drains.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (w_pop || !w_pending) begin
            starve_cnt_d = '0;
        end else if (!w_starve) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
//  Module      : tb_wb_port_arbiter
//  Description : Scoreboard bench for wb_port_arbiter with directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        core_wr_req;
    logic [1:0]  core_src;
    logic [4:0]  core_wr_addr;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic [3:0]  wb_sel;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_md_data;
    logic        core_stall;

    typedef struct {
        string       name;
        logic        en;
        logic [3:0]  sel;
        logic [4:0]  addr;
        logic [31:0] md;
        logic        stall;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;

    wb_port_arbiter #(
        .bit_size   (32),
        .STARVE_MAX (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_wr_req  (core_wr_req),
        .core_src     (core_src),
        .core_wr_addr (core_wr_addr),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .md_valid     (md_valid),
        .md_ready     (md_ready),
        .md_addr      (md_addr),
        .md_data      (md_data),
        .wb_sel       (wb_sel),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_md_data   (wb_md_data),
        .core_stall   (core_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, req);
    endtask

    // Monitor: the outputs are combinational, so every cycle presents a result.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "wb_en",      32'(wb_en),      32'(e.en));
            chk(e.name, "wb_sel",     32'(wb_sel),     32'(e.sel));
            chk(e.name, "wb_addr",    32'(wb_addr),    32'(e.addr));
            chk(e.name, "wb_md_data", wb_md_data,      e.md);
            chk(e.name, "core_stall", 32'(core_stall), 32'(e.stall));
            chk(e.name, "md_ready",   32'(md_ready),   32'(e.rdy));
        end
    end

    // One cycle of stimulus: drive inputs after the edge, then queue the expectation.
    task automatic cyc(input string nm, input logic r,
                       input logic req, input logic [1:0] src, input logic [4:0] wa,
                       input logic [4:0] rs, input logic mv, input logic [4:0] ma,
                       input logic [31:0] md,
                       input logic e_en, input logic [3:0] e_sel, input logic [4:0] e_addr,
                       input logic [31:0] e_md, input logic e_stall, input logic e_rdy,
                       input bit do_chk);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        core_wr_req  = req;
        core_src     = src;
        core_wr_addr = wa;
        rs_addr      = rs;
        rt_addr      = 5'd0;
        md_valid     = mv;
        md_addr      = ma;
        md_data      = md;
        if (do_chk) begin
            e.name  = nm;
            e.en    = e_en;
            e.sel   = e_sel;
            e.addr  = e_addr;
            e.md    = e_md;
            e.stall = e_stall;
            e.rdy   = e_rdy;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; core_wr_req = 1'b0; core_src = 2'd0; core_wr_addr = 5'd0;
        rs_addr = 5'd0; rt_addr = 5'd0; md_valid = 1'b0; md_addr = 5'd0; md_data = 32'd0;

        //  name        rst req src wa  rs  mv ma  md        | en sel      addr md          st rdy chk
        cyc("rst0",     1, 0, 0, 0,  0,  0, 0,  0,          0, 4'b0000, 0,  0,           0, 1, 0);
        cyc("rst1",     1, 0, 0, 0,  0,  0, 0,  0,          0, 4'b0000, 0,  0,           0, 1, 0);
        cyc("idle",     0, 0, 0, 0,  0,  0, 0,  0,          0, 4'b0000, 0,  0,           0, 1, 1);
        // Core-only writes, one per source
        cyc("load7",    0, 1, 1, 7,  0,  0, 0,  0,          1, 4'b0100, 7,  0,           0, 1, 1);
        cyc("lui3",     0, 1, 3, 3,  0,  0, 0,  0,          1, 4'b0010, 3,  0,           0, 1, 1);
        cyc("link31",   0, 1, 2, 31, 0,  0, 0,  0,          1, 4'b0101, 31, 0,           0, 1, 1);
        cyc("alu0",     0, 1, 0, 0,  0,  0, 0,  0,          0, 4'b0000, 0,  0,           0, 1, 1);
        // Single mul/div result while core idle: no same-cycle bypass
        cyc("md9_acc",  0, 0, 0, 0,  0,  1, 9,  32'h1234,   0, 4'b0000, 0,  0,           0, 1, 1);
        cyc("md9_wb",   0, 0, 0, 0,  0,  0, 0,  0,          1, 4'b1000, 9,  32'h1234,    0, 1, 1);
        cyc("md9_done", 0, 0, 0, 0,  0,  0, 0,  0,          0, 4'b0000, 0,  0,           0, 1, 1);
        // Starvation: core writes every cycle, head waits 4 cycles then forces a stall
        cyc("st_acc",   0, 1, 0, 2,  0,  1, 10, 32'hAAAA,   1, 4'b0000, 2,  0,           0, 1, 1);
        cyc("st_w1",    0, 1, 0, 2,  0,  0, 0,  0,          1, 4'b0000, 2,  32'hAAAA,    0, 1, 1);
        cyc("st_w2",    0, 1, 1, 3,  0,  0, 0,  0,          1, 4'b0100, 3,  32'hAAAA,    0, 1, 1);
        cyc("st_w3",    0, 1, 0, 4,  0,  0, 0,  0,          1, 4'b0000, 4,  32'hAAAA,    0, 1, 1);
        cyc("st_w4",    0, 1, 0, 6,  0,  0, 0,  0,          1, 4'b0000, 6,  32'hAAAA,    0, 1, 1);
        cyc("st_drain", 0, 1, 0, 2,  0,  0, 0,  0,          1, 4'b1000, 10, 32'hAAAA,    1, 1, 1);
        cyc("st_after", 0, 1, 0, 2,  0,  0, 0,  0,          1, 4'b0000, 2,  0,           0, 1, 1);
        // RAW hazard on rs: stall and drain in the same cycle, then core proceeds
        cyc("raw_acc",  0, 0, 0, 0,  0,  1, 5,  32'h55,     0, 4'b0000, 0,  0,           0, 1, 1);
        cyc("raw_stl",  0, 1, 0, 8,  5,  0, 0,  0,          1, 4'b1000, 5,  32'h55,      1, 1, 1);
        cyc("raw_go",   0, 1, 0, 8,  5,  0, 0,  0,          1, 4'b0000, 8,  0,           0, 1, 1);
        // WAW hazard on the core destination
        cyc("waw_acc",  0, 0, 0, 0,  0,  1, 14, 32'hE,      0, 4'b0000, 0,  0,           0, 1, 1);
        cyc("waw_stl",  0, 1, 0, 14, 0,  0, 0,  0,          1, 4'b1000, 14, 32'hE,       1, 1, 1);
        cyc("waw_go",   0, 1, 0, 14, 0,  0, 0,  0,          1, 4'b0000, 14, 0,           0, 1, 1);
        // Pending result for $0: no hazard, pops with write disabled
        cyc("z_acc",    0, 0, 0, 0,  0,  1, 0,  32'h77,     0, 4'b0000, 0,  0,           0, 1, 1);
        cyc("z_core",   0, 1, 0, 4,  0,  0, 0,  0,          1, 4'b0000, 4,  32'h77,      0, 1, 1);
        cyc("z_pop",    0, 0, 0, 0,  0,  0, 0,  0,          0, 4'b1000, 0,  32'h77,      0, 1, 1);
        cyc("z_empty",  0, 0, 0, 0,  0,  0, 0,  0,          0, 4'b0000, 0,  0,           0, 1, 1);
        // Back-to-back fill to count=2, then reset mid-fill
        cyc("bb_1",     0, 1, 0, 1,  0,  1, 11, 32'hB1,     1, 4'b0000, 1,  0,           0, 1, 1);
        cyc("bb_2",     0, 1, 0, 1,  0,  1, 12, 32'hB2,     1, 4'b0000, 1,  32'hB1,      0, 1, 1);
        cyc("bb_full",  1, 1, 0, 1,  0,  1, 13, 32'hB3,     1, 4'b0000, 1,  32'hB1,      0, 0, 1);
        cyc("bb_rst1",  0, 0, 0, 0,  0,  0, 0,  0,          0, 4'b0000, 0,  0,           0, 1, 1);
        cyc("bb_rst2",  0, 0, 0, 0,  0,  0, 0,  0,          0, 4'b0000, 0,  0,           0, 1, 1);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
